// File: rtl/vga_scan_controller.sv
`timescale 1ns/1ps
// VGA raster engine: free-running pixel/line counters, delay-aligned sync, blank
// and colour outputs, and a one-clk start-of-frame strobe for the game logic.
module vga_scan_controller #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 2,
  parameter int PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [3:0]  Red_level,
  input  logic [3:0]  Green_level,
  input  logic [3:0]  Blue_level,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PIX_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [PIX_W-1:0] r_pix_cnt;
  logic [10:0]      r_h_cnt;
  logic [10:0]      r_v_cnt;
  logic             r_frame_wrap;
  logic             w_pix_tick;
  logic             w_h_last;
  logic             w_v_last;
  // Bundles are {active, hs, vs}; sync polarity is already active-low here.
  logic [2:0]       w_raw;
  logic [2:0]       w_dly;

  assign w_pix_tick = (r_pix_cnt == PIX_LAST);
  assign w_h_last   = (r_h_cnt == H_LAST);
  assign w_v_last   = (r_v_cnt == V_LAST);
  assign pixelX     = r_h_cnt;
  assign pixelY     = r_v_cnt;

  assign w_raw[2] = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_raw[1] = !((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST));
  assign w_raw[0] = !((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pix_cnt    <= '0;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_frame_wrap <= 1'b0;
      startOfFrame <= 1'b0;
    end else begin
      r_pix_cnt <= w_pix_tick ? '0 : r_pix_cnt + 1'b1;
      if (w_pix_tick) begin
        if (w_h_last) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 11'd1;
        end
      end
      // Strobe lands one clk after the counters show (0,0), never out of reset.
      r_frame_wrap <= w_pix_tick && w_h_last && w_v_last;
      startOfFrame <= r_frame_wrap;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_direct
      assign w_dly = w_raw;
    end else begin : g_pipe
      logic [2:0] r_dly [PIPE_DELAY];
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_DELAY; i++) r_dly[i] <= 3'b011;
        end else begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < PIPE_DELAY; i++) r_dly[i] <= r_dly[i-1];
        end
      end
      assign w_dly = r_dly[PIPE_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      VGA_R       <= 4'd0;
      VGA_G       <= 4'd0;
      VGA_B       <= 4'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      VGA_HS      <= w_dly[1];
      VGA_VS      <= w_dly[0];
      VGA_BLANK_N <= w_dly[2];
      VGA_R       <= w_dly[2] ? Red_level   : 4'd0;
      VGA_G       <= w_dly[2] ? Green_level : 4'd0;
      VGA_B       <= w_dly[2] ? Blue_level  : 4'd0;
    end
  end
endmodule

// File: tb/tb_vga_scan_controller.sv
`timescale 1ns/1ps
// Bench for vga_scan_controller: two reduced-geometry builds checked cycle by cycle
// against a model that derives everything from the clk count since reset release.
module tb_vga_scan_controller;
  localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
  localparam int VA = 6,  VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [3:0] red_in = 4'd0, green_in = 4'd0, blue_in = 4'd0;

  logic [10:0] px_a, py_a, px_b, py_b;
  logic sof_a, hs_a, vs_a, bl_a, sof_b, hs_b, vs_b, bl_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int total = 0;
  int bad   = 0;
  int t_cnt;
  logic [11:0] rgb_smp;

  int    f_lo [7] = '{27, 16, 15, 14, 13, 12, 0};
  int    f_wd [7] = '{11, 11, 1, 1, 1, 1, 12};
  string f_nm [7] = '{"pixelX", "pixelY", "startOfFrame", "VGA_HS", "VGA_VS", "VGA_BLANK_N", "RGB"};

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIX_DIV(2), .PIPE_DELAY(1)
  ) dut_a (
    .clk(clk), .resetN(resetN),
    .Red_level(red_in), .Green_level(green_in), .Blue_level(blue_in),
    .pixelX(px_a), .pixelY(py_a), .startOfFrame(sof_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a)
  );

  vga_scan_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .PIX_DIV(1), .PIPE_DELAY(0)
  ) dut_b (
    .clk(clk), .resetN(resetN),
    .Red_level(red_in), .Green_level(green_in), .Blue_level(blue_in),
    .pixelX(px_b), .pixelY(py_b), .startOfFrame(sof_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b)
  );

  logic [37:0] obs_a, obs_b;
  assign obs_a = {px_a, py_a, sof_a, hs_a, vs_a, bl_a, r_a, g_a, b_a};
  assign obs_b = {px_b, py_b, sof_b, hs_b, vs_b, bl_b, r_b, g_b, b_b};

  always #5 clk = ~clk;

  // Rising edges since reset release, and the colour each edge sampled.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) t_cnt <= 0;
    else         t_cnt <= t_cnt + 1;
  end
  always @(posedge clk) rgb_smp <= {red_in, green_in, blue_in};

  // Expected outputs after t edges: coordinates from pixel index t/div, video outputs
  // from the coordinate that stood pd+1 edges earlier.
  function automatic logic [37:0] model(int t, int div, int pd, logic [11:0] rgb);
    int p, h, v, s;
    logic [10:0] x, y;
    logic sof, hs, vs, bl;
    logic [11:0] c;
    p   = t / div;
    x   = 11'(p % HT);
    y   = 11'((p / HT) % VT);
    sof = (t > 1) && (((t - 1) % (div * HT * VT)) == 0);
    s   = t - 1 - pd;
    hs = 1'b1; vs = 1'b1; bl = 1'b0; c = 12'd0;
    if (s >= 0) begin
      p  = s / div;
      h  = p % HT;
      v  = (p / HT) % VT;
      bl = (h < HA) && (v < VA);
      hs = !((h >= HA + HF) && (h < HA + HF + HSW));
      vs = !((v >= VA + VF) && (v < VA + VF + VSW));
      c  = bl ? rgb : 12'd0;
    end
    return {x, y, sof, hs, vs, bl, c};
  endfunction

  task automatic test_reset();
    logic [37:0] e;
    red_in = 4'hF; green_in = 4'h5; blue_in = 4'hA;
    repeat (3) @(negedge clk);
    e = model(0, 2, 1, 12'h000);
    total++;
    if (obs_a !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", obs_a, e); end
    e = model(0, 1, 0, 12'h000);
    total++;
    if (obs_b !== e) begin bad++; $display("FAIL reset_b got=%h exp=%h", obs_b, e); end
    resetN = 1'b1;
    @(negedge clk);
    total++;
    if (px_a !== 11'd0 || hs_a !== 1'b1 || bl_a !== 1'b0)
      begin bad++; $display("FAIL release_edge1 got px=%0d hs=%b bl=%b exp px=0 hs=1 bl=0", px_a, hs_a, bl_a); end
    @(negedge clk);
    total++;
    if (px_a !== 11'd1) begin bad++; $display("FAIL release_edge2 got px=%0d exp px=1", px_a); end
    $display("test_reset done t=%0d", t_cnt);
  endtask

  task automatic test_random_frames(int ncyc);
    logic [37:0] e, ea, eb, g, m;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      ea = model(t_cnt, 2, 1, rgb_smp);
      eb = model(t_cnt, 1, 0, rgb_smp);
      for (int f = 0; f < 7; f++) begin
        m = (38'd1 << f_wd[f]) - 38'd1;
        g = (obs_a >> f_lo[f]) & m;
        e = (ea >> f_lo[f]) & m;
        total++;
        if (g !== e) begin bad++; $display("FAIL random_a_%s t=%0d got=%h exp=%h", f_nm[f], t_cnt, g, e); end
      end
      total++;
      if (obs_b !== eb) begin bad++; $display("FAIL random_b t=%0d got=%h exp=%h", t_cnt, obs_b, eb); end
      {red_in, green_in, blue_in} = 12'($urandom);
    end
    $display("test_random_frames done cycles=%0d", ncyc);
  endtask

  // Emulates a 1-clk registered priority stage producing RGB = pixelX[3:0].
  task automatic test_alignment(int ncyc);
    logic [37:0] e;
    logic [11:0] exp_c;
    logic [3:0]  prev_x;
    int col;
    prev_x = px_a[3:0];
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (n >= 3) begin
        e   = model(t_cnt, 2, 1, 12'h000);
        col = ((t_cnt - 2) / 2) % HT;
        exp_c = e[12] ? {3{4'(col)}} : 12'd0;
        total++;
        if (bl_a !== e[12]) begin bad++; $display("FAIL align_blank t=%0d got=%b exp=%b", t_cnt, bl_a, e[12]); end
        total++;
        if ({r_a, g_a, b_a} !== exp_c) begin bad++; $display("FAIL align_rgb t=%0d col=%0d got=%h exp=%h", t_cnt, col, {r_a, g_a, b_a}, exp_c); end
      end
      red_in = prev_x; green_in = prev_x; blue_in = prev_x;
      prev_x = px_a[3:0];
    end
    $display("test_alignment done cycles=%0d", ncyc);
  endtask

  task automatic test_mid_reset(int ncyc);
    logic [37:0] e;
    int n;
    n = 0;
    while (!(py_a == 11'd3 && px_a == 11'd10) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 1000) begin bad++; $display("FAIL mid_reset_reach got=(%0d,%0d) exp=(10,3)", px_a, py_a); end
    resetN = 1'b0;
    #1;
    e = model(0, 2, 1, 12'h000);
    total++;
    if (obs_a !== e) begin bad++; $display("FAIL mid_reset_async_a got=%h exp=%h", obs_a, e); end
    e = model(0, 1, 0, 12'h000);
    total++;
    if (obs_b !== e) begin bad++; $display("FAIL mid_reset_async_b got=%h exp=%h", obs_b, e); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      e = model(t_cnt, 2, 1, rgb_smp);
      total++;
      if (obs_a !== e) begin bad++; $display("FAIL mid_reset_run t=%0d got=%h exp=%h", t_cnt, obs_a, e); end
      {red_in, green_in, blue_in} = 12'($urandom);
    end
    $display("test_mid_reset done cycles=%0d", ncyc);
  endtask

  task automatic test_fast_build(int ncyc);
    logic [37:0] e;
    logic [10:0] prev_px;
    int last_wrap;
    last_wrap = -1;
    prev_px = px_b;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      e = model(t_cnt, 1, 0, rgb_smp);
      total++;
      if (obs_b !== e) begin bad++; $display("FAIL fast_build t=%0d got=%h exp=%h", t_cnt, obs_b, e); end
      if (px_b == 11'd0 && prev_px == 11'(HT - 1)) begin
        if (last_wrap >= 0) begin
          total++;
          if (t_cnt - last_wrap != HT)
            begin bad++; $display("FAIL fast_line_period got=%0d exp=%0d", t_cnt - last_wrap, HT); end
        end
        last_wrap = t_cnt;
      end
      prev_px = px_b;
      {red_in, green_in, blue_in} = 12'($urandom);
    end
    $display("test_fast_build done cycles=%0d", ncyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0d", t_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_random_frames(2 * 2 * HT * VT + 60);
    test_alignment(2 * HT * VT + 40);
    test_mid_reset(2 * HT * VT + 40);
    test_fast_build(3 * HT * VT);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
